dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single data-memory port between the pipeline's MEM stage (core) and a debug/loader port (dbg).
- Arbitration is core-priority with a starvation guard: after a bounded run of consecutive core grants, a waiting debug request wins one slot.
- The block sits between the MEM stage and the data memory.
- It drives the memory's address/write_data/mem_write/mem_read.
- It returns registered read data and a stall to the pipeline hazard logic.

## Interface
- ADDRESS_LINE, 8, address width of the data memory
- MAX_CORE_BURST, 4, consecutive core grants allowed while dbg waits before dbg wins a slot; must be 1..15
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- core_req  input  1  core requests an access this cycle
- core_we  input  1  1 = write, 0 = read
- core_addr  input  ADDRESS_LINE  core address
- core_wdata  input  8  core write data
- core_gnt  output  1  core access performed this cycle (combinational)
- core_stall  output  1  core_req & ~core_gnt
- core_rdata  output  8  registered read data for the last granted core read
- core_rvalid  output  1  one-cycle pulse; core_rdata is valid
- dbg_req, dbg_we, dbg_addr, dbg_wdata  inputs  1/1/ADDRESS_LINE/8  same meaning for the debug port
- dbg_gnt, dbg_rdata, dbg_rvalid  outputs  1/8/1  same meaning for the debug port
- mem_address  output  ADDRESS_LINE  to memory address
- mem_write_data  output  8  to memory write_data
- mem_write  output  1  to memory mem_write
- mem_read  output  1  to memory mem_read
- mem_read_data  input  8  from memory read_data (combinational read)

## Operation
- The starvation counter is starve_cnt, $clog2(MAX_CORE_BURST+1) bits, saturating at MAX_CORE_BURST.
- FSM has two states:
  - CORE_PRI: core_req wins; dbg is granted only when core_req=0.
  - DBG_FORCE: dbg_req wins; core is stalled.
- Transitions, evaluated at each clock edge:
  - CORE_PRI to DBG_FORCE when the next starve_cnt equals MAX_CORE_BURST and dbg_req=1.
  - DBG_FORCE to CORE_PRI unconditionally after one cycle, whether dbg was granted or dbg_req dropped.
- Counter updates:
  - Increments when core_gnt=1 and dbg_req=1.
  - Clears on any dbg_gnt.
  - Clears when dbg_req=0.
  - Holds otherwise.
- Exactly one grant or none per cycle; core_gnt and dbg_gnt are never both 1.
- The memory-side mux selects the granted requester's addr/wdata.
  - mem_write = gnt & we.
  - mem_read = gnt & ~we.
  - With no grant: mem_address=0, mem_write_data=0, mem_write=0, mem_read=0.
- Reads:
  - mem_read_data is sampled at the grant cycle's edge into the granted port's rdata register.
  - That port's rvalid pulses high for exactly the following cycle.
  - The other port's rdata holds its value.
- Writes commit in the memory at the grant cycle's edge. No rvalid is produced for a write.

## Timing
- Grant, stall and memory-side outputs are combinational from requests and registered state; there is no added request latency.
- Read latency is 1 cycle: request plus grant in cycle N, rdata/rvalid in cycle N+1.
- Back-to-back granted reads give an rvalid pulse every cycle.
- Write then read of the same address in consecutive cycles returns the new data, because the write commits at the edge between them.
- Requesters hold req/we/addr/wdata stable until granted. A request dropped before grant is simply lost.
- Reset values:
  - All outputs 0.
  - core_rdata = dbg_rdata = 0.
  - state = CORE_PRI, starve_cnt = 0.
- Reset asserted mid-operation: a read granted in the reset cycle produces no rvalid, and no memory access is issued during reset (mem_write = mem_read = 0).

## Test plan
- Reset check: assert reset 2 cycles with both reqs high. Required: all outputs 0, no mem_write, no mem_read.
- Core read: after reset (memory reset contents addr1=5, addr2=6), core reads addr 1 then addr 2 on consecutive cycles. Required: core_gnt=1 both cycles; core_rvalid pulses with core_rdata=5 then 6; dbg outputs unchanged.
- Debug write then core read: dbg writes 8'hA5 to addr 10 with core idle, then core reads addr 10 next cycle. Required: core_rdata=8'hA5 one cycle later.
- Starvation guard, MAX_CORE_BURST=4, core_req and dbg_req held continuously:
  - Grants follow the pattern core, core, core, core, dbg, repeating.
  - core_stall=1 exactly on every dbg-grant cycle.
- dbg_req drops mid-burst: dbg_req high 2 cycles then low, core_req continuous. Required: starve_cnt returns to 0, core is never stalled, dbg is never granted.
- Reset mid-read: core read granted and reset asserted in the same cycle. Required: no core_rvalid in the next cycle, core_rdata=0, state CORE_PRI.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of every request, response and memory-side signal
// around the data-memory arbiter.
//   core_*  : MEM-stage requester (req/we/addr/wdata in; gnt/stall/rdata/rvalid out)
//   dbg_*   : debug/loader requester (req/we/addr/wdata in; gnt/rdata/rvalid out)
//   mem_*   : data-memory port (address/write_data/write/read out; read_data in)
// Modport slave is taken by the arbiter; master is the view of the requesters
// and the memory seen together from the outside.
interface dmem_arbiter_if #(
    parameter int unsigned ADDRESS_LINE = 8
);
    logic                    core_req;
    logic                    core_we;
    logic [ADDRESS_LINE-1:0] core_addr;
    logic [7:0]              core_wdata;
    logic                    core_gnt;
    logic                    core_stall;
    logic [7:0]              core_rdata;
    logic                    core_rvalid;

    logic                    dbg_req;
    logic                    dbg_we;
    logic [ADDRESS_LINE-1:0] dbg_addr;
    logic [7:0]              dbg_wdata;
    logic                    dbg_gnt;
    logic [7:0]              dbg_rdata;
    logic                    dbg_rvalid;

    logic [ADDRESS_LINE-1:0] mem_address;
    logic [7:0]              mem_write_data;
    logic                    mem_write;
    logic                    mem_read;
    logic [7:0]              mem_read_data;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_gnt, core_stall, core_rdata, core_rvalid,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rdata, dbg_rvalid,
        output mem_address, mem_write_data, mem_write, mem_read,
        input  mem_read_data
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_gnt, core_stall, core_rdata, core_rvalid,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rdata, dbg_rvalid,
        input  mem_address, mem_write_data, mem_write, mem_read,
        output mem_read_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the core MEM stage
// and the debug/loader port. Core has priority; after MAX_CORE_BURST
// consecutive core grants with debug waiting, debug is forced one slot.
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : dmem_arbiter_if.slave (requests, grants, read data, memory port)
// Grants, stall and memory-side outputs are combinational; read data and
// rvalid are registered one cycle after the grant.
module dmem_arbiter #(
    parameter int unsigned ADDRESS_LINE   = 8,
    parameter int unsigned MAX_CORE_BURST = 4
) (
    input logic           clock,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    localparam int unsigned CntW = $clog2(MAX_CORE_BURST + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_CORE_BURST);

    typedef enum logic [0:0] {StCorePri, StDbgForce} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         starve_cnt_q, starve_cnt_d;
    logic [7:0]              core_rdata_q, core_rdata_d;
    logic                    core_rvalid_q, core_rvalid_d;
    logic [7:0]              dbg_rdata_q, dbg_rdata_d;
    logic                    dbg_rvalid_q, dbg_rvalid_d;

    logic                    core_gnt;
    logic                    dbg_gnt;
    logic [ADDRESS_LINE-1:0] sel_addr;
    logic [7:0]              sel_wdata;
    logic                    sel_write;
    logic                    sel_read;

    always_comb begin
        core_gnt      = 1'b0;
        dbg_gnt       = 1'b0;
        sel_addr      = '0;
        sel_wdata     = '0;
        sel_write     = 1'b0;
        sel_read      = 1'b0;
        state_d       = state_q;
        starve_cnt_d  = starve_cnt_q;
        core_rdata_d  = core_rdata_q;
        dbg_rdata_d   = dbg_rdata_q;
        core_rvalid_d = 1'b0;
        dbg_rvalid_d  = 1'b0;

        // No grant, hence no memory access, while reset is asserted.
        if (!reset) begin
            unique case (state_q)
                StCorePri: begin
                    core_gnt = bus.core_req;
                    dbg_gnt  = bus.dbg_req & ~bus.core_req;
                end
                StDbgForce: begin
                    dbg_gnt = bus.dbg_req;
                end
            endcase
        end

        if (core_gnt) begin
            sel_addr  = bus.core_addr;
            sel_wdata = bus.core_wdata;
            sel_write = bus.core_we;
            sel_read  = ~bus.core_we;
        end else if (dbg_gnt) begin
            sel_addr  = bus.dbg_addr;
            sel_wdata = bus.dbg_wdata;
            sel_write = bus.dbg_we;
            sel_read  = ~bus.dbg_we;
        end

        // Counts core grants taken while debug is kept waiting.
        if (dbg_gnt || !bus.dbg_req) begin
            starve_cnt_d = '0;
        end else if (core_gnt && starve_cnt_q != CntMax) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end

        unique case (state_q)
            StCorePri: begin
                if (starve_cnt_d == CntMax && bus.dbg_req) begin
                    state_d = StDbgForce;
                end
            end
            StDbgForce: begin
                state_d = StCorePri;
            end
        endcase

        if (core_gnt && !bus.core_we) begin
            core_rdata_d  = bus.mem_read_data;
            core_rvalid_d = 1'b1;
        end
        if (dbg_gnt && !bus.dbg_we) begin
            dbg_rdata_d  = bus.mem_read_data;
            dbg_rvalid_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StCorePri;
            starve_cnt_q  <= '0;
            core_rdata_q  <= '0;
            core_rvalid_q <= 1'b0;
            dbg_rdata_q   <= '0;
            dbg_rvalid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_cnt_q  <= starve_cnt_d;
            core_rdata_q  <= core_rdata_d;
            core_rvalid_q <= core_rvalid_d;
            dbg_rdata_q   <= dbg_rdata_d;
            dbg_rvalid_q  <= dbg_rvalid_d;
        end
    end

    assign bus.core_gnt       = core_gnt;
    assign bus.core_stall     = bus.core_req & ~core_gnt & ~reset;
    assign bus.core_rdata     = core_rdata_q;
    assign bus.core_rvalid    = core_rvalid_q;
    assign bus.dbg_gnt        = dbg_gnt;
    assign bus.dbg_rdata      = dbg_rdata_q;
    assign bus.dbg_rvalid     = dbg_rvalid_q;
    assign bus.mem_address    = sel_addr;
    assign bus.mem_write_data = sel_wdata;
    assign bus.mem_write      = sel_write;
    assign bus.mem_read       = sel_read;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized bench for dmem_arbiter. A small
// behavioural memory sits on the memory port; an independent reference model
// (grant rule, waiting-run count, shadow memory image) predicts every output.
module tb_dmem_arbiter;
    localparam int unsigned AW  = 8;
    localparam int unsigned MAX = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    dmem_arbiter_if #(.ADDRESS_LINE(AW)) bus ();

    dmem_arbiter #(
        .ADDRESS_LINE  (AW),
        .MAX_CORE_BURST(MAX)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // Behavioural data memory: combinational read, write at the clock edge.
    logic [7:0] mem [256];
    bit         mem_loaded;
    always @(posedge clock) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i + 4);
            mem_loaded <= 1'b1;
        end else if (bus.mem_write) begin
            mem[bus.mem_address] <= bus.mem_write_data;
        end
    end
    assign bus.mem_read_data = mem[bus.mem_address];

    // Reference model state.
    logic [7:0]  ref_mem [256];
    logic [7:0]  ref_core_rdata, ref_dbg_rdata;
    logic        ref_core_rvalid, ref_dbg_rvalid;
    int unsigned ref_run;    // core grants in a row while debug waits
    logic        ref_force;  // this slot belongs to debug

    int unsigned n_total, n_pass, n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic creq, input logic cwe,
                        input logic [7:0] caddr, input logic [7:0] cwd,
                        input logic dreq, input logic dwe,
                        input logic [7:0] daddr, input logic [7:0] dwd);
        logic       e_cg, e_dg, e_w, e_r;
        logic [7:0] e_addr, e_wd;
        reset          = rst;
        bus.core_req   = creq;
        bus.core_we    = cwe;
        bus.core_addr  = caddr;
        bus.core_wdata = cwd;
        bus.dbg_req    = dreq;
        bus.dbg_we     = dwe;
        bus.dbg_addr   = daddr;
        bus.dbg_wdata  = dwd;
        #1;
        e_cg = 1'b0;
        e_dg = 1'b0;
        if (!rst) begin
            if (ref_force) e_dg = dreq;
            else begin
                e_cg = creq;
                e_dg = dreq & ~creq;
            end
        end
        e_addr = e_cg ? caddr : (e_dg ? daddr : 8'h00);
        e_wd   = e_cg ? cwd : (e_dg ? dwd : 8'h00);
        e_w    = (e_cg & cwe) | (e_dg & dwe);
        e_r    = (e_cg & ~cwe) | (e_dg & ~dwe);

        check("core_gnt", 32'(bus.core_gnt), 32'(e_cg));
        check("dbg_gnt", 32'(bus.dbg_gnt), 32'(e_dg));
        check("core_stall", 32'(bus.core_stall), 32'(creq & ~e_cg & ~rst));
        check("mem_address", 32'(bus.mem_address), 32'(e_addr));
        check("mem_write_data", 32'(bus.mem_write_data), 32'(e_wd));
        check("mem_write", 32'(bus.mem_write), 32'(e_w));
        check("mem_read", 32'(bus.mem_read), 32'(e_r));
        check("core_rdata", 32'(bus.core_rdata), 32'(ref_core_rdata));
        check("core_rvalid", 32'(bus.core_rvalid), 32'(ref_core_rvalid));
        check("dbg_rdata", 32'(bus.dbg_rdata), 32'(ref_dbg_rdata));
        check("dbg_rvalid", 32'(bus.dbg_rvalid), 32'(ref_dbg_rvalid));
        check("starve_cnt", 32'(dut.starve_cnt_q), ref_run);

        if (rst) begin
            ref_core_rdata  = 8'h00;
            ref_dbg_rdata   = 8'h00;
            ref_core_rvalid = 1'b0;
            ref_dbg_rvalid  = 1'b0;
            ref_run         = 0;
            ref_force       = 1'b0;
        end else begin
            ref_core_rvalid = e_cg & ~cwe;
            ref_dbg_rvalid  = e_dg & ~dwe;
            if (ref_core_rvalid) ref_core_rdata = ref_mem[caddr];
            if (ref_dbg_rvalid) ref_dbg_rdata = ref_mem[daddr];
            if (e_w) ref_mem[e_addr] = e_wd;
            if (e_dg || !dreq) ref_run = 0;
            else if (e_cg && ref_run < MAX) ref_run++;
            ref_force = !ref_force && ref_run == MAX && dreq;
        end
        @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i + 4);
        ref_core_rdata  = 8'h00;
        ref_dbg_rdata   = 8'h00;
        ref_core_rvalid = 1'b0;
        ref_dbg_rvalid  = 1'b0;
        ref_run         = 0;
        ref_force       = 1'b0;
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        reset          = 1'b1;
        bus.core_req   = 1'b1;
        bus.core_we    = 1'b0;
        bus.core_addr  = 8'h01;
        bus.core_wdata = 8'h00;
        bus.dbg_req    = 1'b1;
        bus.dbg_we     = 1'b0;
        bus.dbg_addr   = 8'h02;
        bus.dbg_wdata  = 8'h00;
        @(negedge clock);

        // Reset with both requests high: everything quiet.
        repeat (2) step(1, 1, 0, 8'd1, 8'h00, 1, 0, 8'd2, 8'h00);

        // Core reads addr 1 then 2 back to back (expect 5, 6).
        step(0, 1, 0, 8'd1, 8'h00, 0, 0, 8'd0, 8'h00);
        step(0, 1, 0, 8'd2, 8'h00, 0, 0, 8'd0, 8'h00);
        step(0, 0, 0, 8'd0, 8'h00, 0, 0, 8'd0, 8'h00);
        step(0, 0, 0, 8'd0, 8'h00, 0, 0, 8'd0, 8'h00);

        // Debug write A5 to addr 10, then core reads it next cycle.
        step(0, 0, 0, 8'd0, 8'h00, 1, 1, 8'd10, 8'hA5);
        step(0, 1, 0, 8'd10, 8'h00, 0, 0, 8'd0, 8'h00);
        step(0, 0, 0, 8'd0, 8'h00, 0, 0, 8'd0, 8'h00);

        // Both requesting continuously: core x4, dbg, repeating.
        repeat (12) step(0, 1, 0, 8'd3, 8'h00, 1, 0, 8'd4, 8'h00);
        step(0, 0, 0, 8'd0, 8'h00, 0, 0, 8'd0, 8'h00);

        // Debug request drops before the burst limit.
        repeat (2) step(0, 1, 0, 8'd5, 8'h00, 1, 0, 8'd6, 8'h00);
        repeat (4) step(0, 1, 0, 8'd5, 8'h00, 0, 0, 8'd6, 8'h00);

        // Core read coincides with reset: no rvalid afterwards, rdata cleared.
        step(0, 1, 0, 8'd7, 8'h00, 0, 0, 8'd0, 8'h00);
        step(1, 1, 0, 8'd8, 8'h00, 0, 0, 8'd0, 8'h00);
        step(0, 0, 0, 8'd0, 8'h00, 0, 0, 8'd0, 8'h00);
        step(0, 0, 0, 8'd0, 8'h00, 0, 0, 8'd0, 8'h00);

        // Random traffic, biased toward contention, with occasional reset.
        repeat (500) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 15)), 8'($urandom),
                 ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 15)), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
